// File: rtl/biu_slave.sv
// biu_slave: responder on the shared tri-state system bus.
// Decodes requests that fall in [BASE_ADDR, BASE_ADDR+ADDR_SPAN), hands them to a
// local device over a req/ack handshake and drives the read response back onto the bus
// for one cycle.
// Optional feature: define BIU_SLAVE_TIMEOUT_EN to add a device-ack timeout that
// returns ERR_DATA on reads and sets the sticky timeout flag.
module biu_slave #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN      = 32'h0000_1000,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [ADDR_WIDTH-1:0] bus_address,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    inout  wire  [1:0]            bus_control,
    output logic                  dev_req,
    output logic                  dev_rnw,
    output logic [ADDR_WIDTH-1:0] dev_addr,
    output logic [DATA_WIDTH-1:0] dev_wdata,
    input  logic [DATA_WIDTH-1:0] dev_rdata,
    input  logic                  dev_ack,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout
);

    // Elaboration-time sanity checks on the configuration.
    if (ADDR_SPAN == '0) begin : g_chk_span
        $error("biu_slave: ADDR_SPAN must be nonzero");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
        $error("biu_slave: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEV_REQ   = 2'd1,
        DRIVE_RSP = 2'd2
    } state_t;

    // Window bounds carry one extra bit so a window touching the top of the
    // address space does not wrap to zero.
    localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + {1'b0, ADDR_SPAN};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rnw_q, rnw_d;
    logic                  overrun_q, overrun_d;

    logic [ADDR_WIDTH:0]   addr_ext;
    logic                  in_win;
    logic                  hit;
    logic                  drive;
    logic                  tmo_fire;

    assign addr_ext = {1'b0, bus_address};
    assign in_win   = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    // Our own data_valid during DRIVE_RSP must never look like a new request.
    assign hit      = bus_control[0] && in_win && (state_q != DRIVE_RSP);
    assign drive    = (state_q == DRIVE_RSP);

    // Bus is released whenever we are not presenting a read response; since
    // state_q resets asynchronously the release is immediate on rst.
    assign bus_address = drive ? addr_q  : {ADDR_WIDTH{1'bz}};
    assign bus_data    = drive ? rdata_q : {DATA_WIDTH{1'bz}};
    assign bus_control = drive ? 2'b11   : 2'bzz;

    assign dev_req   = (state_q == DEV_REQ);
    assign dev_rnw   = rnw_q;
    assign dev_addr  = addr_q - BASE_ADDR;
    assign dev_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

`ifdef BIU_SLAVE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Expiry is the last permitted wait cycle without an ack; an ack in that
    // same cycle wins and the transfer completes normally.
    assign tmo_fire = (state_q == DEV_REQ) && !dev_ack && (cnt_q == CNT_LAST);
    assign timeout  = timeout_q;

    // Wait-cycle counter runs only in DEV_REQ and sits at zero otherwise, so it is clear on entry.
    always_comb begin
        cnt_d     = '0;
        timeout_d = timeout_q | tmo_fire;
        if (state_q == DEV_REQ) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timeout counter and sticky flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Next-state and latch logic for the request/response sequence.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rnw_d     = rnw_q;
        rdata_d   = rdata_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    addr_d  = bus_address;
                    wdata_d = bus_data;
                    rnw_d   = bus_control[1];
                    state_d = DEV_REQ;
                end
            end
            DEV_REQ: begin
                if (hit) begin
                    overrun_d = 1'b1;
                end
                if (dev_ack) begin
                    if (rnw_q) begin
                        rdata_d = dev_rdata;
                        state_d = DRIVE_RSP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo_fire) begin
                    if (rnw_q) begin
                        rdata_d = ERR_DATA;
                        state_d = DRIVE_RSP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRIVE_RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, transfer latches and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rnw_q     <= 1'b0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rnw_q     <= rnw_d;
            rdata_q   <= rdata_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_biu_slave.sv
// Testbench for biu_slave: bus master + device model, scoreboarded checks.
`timescale 1ns/1ps
module tb_biu_slave;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] SPAN = 32'h0000_1000;
    localparam int          TMO  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wire [AW-1:0] bus_address;
    wire [DW-1:0] bus_data;
    wire [1:0]    bus_control;

    logic          m_drv  = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [1:0]    m_ctrl = '0;

    assign bus_address = m_drv ? m_addr : {AW{1'bz}};
    assign bus_data    = m_drv ? m_data : {DW{1'bz}};
    assign bus_control = m_drv ? m_ctrl : 2'bzz;

    logic          dev_req, dev_rnw, busy, overrun, timeout;
    logic [AW-1:0] dev_addr;
    logic [DW-1:0] dev_wdata;
    logic [DW-1:0] dev_rdata = '0;
    logic          dev_ack   = 1'b0;

    biu_slave #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .BASE_ADDR     (BASE),
        .ADDR_SPAN     (SPAN),
        .TIMEOUT_CYCLES(TMO),
        .ERR_DATA      (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_address(bus_address),
        .bus_data   (bus_data),
        .bus_control(bus_control),
        .dev_req    (dev_req),
        .dev_rnw    (dev_rnw),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_rdata  (dev_rdata),
        .dev_ack    (dev_ack),
        .busy       (busy),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } rsp_t;

    typedef struct packed {
        logic          rnw;
        logic [AW-1:0] off;
        logic [DW-1:0] wdata;
    } devx_t;

    rsp_t  rsp_q[$];
    devx_t dev_q[$];

    // Device model: acks dly_cfg cycles after dev_req first seen (0 = same cycle).
    bit          ack_en  = 1'b1;
    int          dly_cfg = 0;
    logic [31:0] rd_cfg  = '0;

    initial begin
        int w;
        w = 0;
        forever begin
            @(posedge clk);
            #1;
            dev_ack = 1'b0;
            if (dev_req && ack_en && !rst) begin
                if (w >= dly_cfg) begin
                    dev_ack   = 1'b1;
                    dev_rdata = rd_cfg;
                    w         = 0;
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    // Monitors: device-side request and bus-side response, sampled on negedge.
    initial begin
        logic  req_prev;
        devx_t dexp;
        rsp_t  rexp;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dev_req && !req_prev) begin
                    if (dev_q.size() == 0) begin
                        check("dev_req_unexpected", 1, 0);
                    end else begin
                        dexp = dev_q.pop_front();
                        check("dev_rnw", dev_rnw, dexp.rnw);
                        check("dev_addr", dev_addr, dexp.off);
                        if (!dexp.rnw) check("dev_wdata", dev_wdata, dexp.wdata);
                    end
                end
                if ((bus_control[0] === 1'b1) && !m_drv) begin
                    if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        rexp = rsp_q.pop_front();
                        check("rsp_addr", bus_address, rexp.addr);
                        check("rsp_data", bus_data, rexp.data);
                        check("rsp_rnw", bus_control[1], 1);
                        check("rsp_cycle", cyc, rexp.cyc);
                    end
                end
            end
            req_prev = dev_req;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle master request; queues the expected device transfer and read response.
    task automatic bus_req(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                           input bit accept, input int lat, input logic [31:0] rsp_data);
        m_addr = a;
        m_data = d;
        m_ctrl = {rnw, 1'b1};
        m_drv  = 1'b1;
        if (accept) begin
            dev_q.push_back(devx_t'{rnw: rnw, off: a - BASE, wdata: d});
            if (rnw) rsp_q.push_back(rsp_t'{addr: a, data: rsp_data, cyc: 32'(cyc + lat)});
        end
        step();
        m_drv  = 1'b0;
        m_ctrl = 2'b00;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || rsp_q.size() != 0 || dev_q.size() != 0) && n < 40) begin
            step();
            n++;
        end
        check({tag, "_done"}, 64'(n < 40), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_dev_req", dev_req, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_bus_valid", 64'(bus_control[0] === 1'b1), 0);
        check("rst_wdata", dev_wdata, 0);
        rst = 1'b0;
        step();

        // Read hit, same-cycle-next ack: response 2 cycles after request.
        dly_cfg = 0;
        rd_cfg  = 32'hCAFE_0001;
        bus_req(1'b1, 32'h0000_1004, 32'h0, 1'b1, 2, 32'hCAFE_0001);
        wait_idle("read_hit");

        // Write hit with a slow device: no bus response.
        dly_cfg = 3;
        bus_req(1'b0, 32'h0000_1008, 32'h1234_5678, 1'b1, 0, 32'h0);
        check("wr_busy_mid", busy, 1);
        wait_idle("write_hit");
        check("wr_idle", busy, 0);

        // Misses just outside the window and a valid-low cycle inside it.
        bus_req(1'b1, 32'h0000_0FFC, 32'h0, 1'b0, 0, 32'h0);
        bus_req(1'b0, 32'h0000_2000, 32'h7777_7777, 1'b0, 0, 32'h0);
        m_addr = 32'h0000_1010;
        m_ctrl = 2'b10;
        m_drv  = 1'b1;
        step();
        m_drv  = 1'b0;
        m_ctrl = 2'b00;
        repeat (3) step();
        check("miss_busy", busy, 0);

        // Last word of the window hits; one device wait cycle adds one cycle.
        dly_cfg = 1;
        rd_cfg  = 32'hA5A5_0FFC;
        bus_req(1'b1, 32'h0000_1FFC, 32'h0, 1'b1, 3, 32'hA5A5_0FFC);
        wait_idle("upper_hit");

        // Overrun: second write while the first is stalled is dropped.
        check("ovr_before", overrun, 0);
        dly_cfg = 2;
        bus_req(1'b0, 32'h0000_1100, 32'h1111_1111, 1'b1, 0, 32'h0);
        bus_req(1'b0, 32'h0000_1104, 32'h2222_2222, 1'b0, 0, 32'h0);
        check("ovr_set", overrun, 1);
        wait_idle("overrun");
        repeat (3) step();
        check("ovr_sticky", overrun, 1);
        check("ovr_idle", busy, 0);

`ifdef BIU_SLAVE_TIMEOUT_EN
        // Ack in the final permitted cycle completes normally.
        dly_cfg = TMO - 1;
        rd_cfg  = 32'h0BAD_F00D;
        bus_req(1'b1, 32'h0000_1020, 32'h0, 1'b1, 2 + TMO - 1, 32'h0BAD_F00D);
        wait_idle("tmo_late_ack");
        check("tmo_clear", timeout, 0);
        // No ack: error data after TMO cycles in DEV_REQ.
        ack_en = 1'b0;
        bus_req(1'b1, 32'h0000_1024, 32'h0, 1'b1, 1 + TMO, 32'hDEAD_BEEF);
        wait_idle("tmo_expire");
        check("tmo_set", timeout, 1);
        ack_en = 1'b1;
`else
        check("tmo_tied", timeout, 0);
`endif

        // Asynchronous reset while the response is on the bus.
        dly_cfg = 0;
        rd_cfg  = 32'h5555_AAAA;
        bus_req(1'b1, 32'h0000_1010, 32'h0, 1'b1, 2, 32'h5555_AAAA);
        v = rsp_q.pop_back();
        step();
        check("rst_pre_drive", 64'(bus_control[0] === 1'b1), 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_bus", 64'(bus_control[0] === 1'b1), 0);
        check("rst_async_req", dev_req, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_ovr", overrun, 0);
        check("rst_async_tmo", timeout, 0);
        step();
        rst = 1'b0;
        step();

        // Recovery after reset.
        dly_cfg = 0;
        rd_cfg  = 32'h0123_4567;
        bus_req(1'b1, 32'h0000_1FF0, 32'h0, 1'b1, 2, 32'h0123_4567);
        wait_idle("post_rst");

        repeat (3) step();
        check("rsp_q_empty", rsp_q.size(), 0);
        check("dev_q_empty", dev_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
